// File: rtl/tboom_rename_pkg.sv
// Shared rename-stage types and reset constants for the TinyBOOM free list.
// Used by tboom_free_list and tboom_fl_checkpoint_buf.
package tboom_rename_pkg;

  localparam int FL_PHYS_WIDTH       = 6;
  localparam int FL_NUM_PHYS_REGS    = 64;
  localparam int FL_NUM_ARCH_REGS    = 32;
  localparam int FL_CHECKPOINT_DEPTH = 8;
  localparam int FL_PTR_WIDTH        = $clog2(FL_NUM_PHYS_REGS) + 1;

  typedef logic [FL_PHYS_WIDTH-1:0] phys_reg_t;
  typedef logic [FL_PTR_WIDTH-1:0]  fl_ptr_t;

  // Reset image: entry idx holds the first register not mapped to an
  // architectural register, counting upward.
  function automatic int fl_reset_fill(input int num_arch_regs, input int idx);
    return num_arch_regs + idx;
  endfunction

endpackage

// File: rtl/tboom_fl_checkpoint_buf.sv
// Head-pointer snapshot register file: one write port, one combinational read port.
// Instantiated by tboom_free_list only when TBOOM_FREE_LIST_CHECKPOINT_EN is defined.
module tboom_fl_checkpoint_buf
  import tboom_rename_pkg::*;
#(
  parameter int DEPTH = FL_CHECKPOINT_DEPTH,
  parameter int PTR_W = FL_PTR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_pos,
  input  logic [PTR_W-1:0]         wr_ptr,
  input  logic [$clog2(DEPTH)-1:0] rd_pos,
  output logic [PTR_W-1:0]         rd_ptr
);

  logic [PTR_W-1:0] slots [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (wr_en) begin
      slots[wr_pos] <= wr_ptr;
    end
  end

  assign rd_ptr = slots[rd_pos];

endmodule

// File: rtl/tboom_free_list.sv
// Physical-register free list: circular FIFO, two grants per cycle, two frees per cycle.
// Head-pointer checkpoint/restore is present only with TBOOM_FREE_LIST_CHECKPOINT_EN.
module tboom_free_list
  import tboom_rename_pkg::*;
#(
  parameter int PHYS_WIDTH       = FL_PHYS_WIDTH,
  parameter int NUM_PHYS_REGS    = FL_NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS    = FL_NUM_ARCH_REGS,
  parameter int CHECKPOINT_DEPTH = FL_CHECKPOINT_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i0_freelist_request,
  input  logic                                i1_freelist_request,
  output logic                                i0_alloc_valid,
  output logic [PHYS_WIDTH-1:0]               i0_alloc_phys,
  output logic                                i1_alloc_valid,
  output logic [PHYS_WIDTH-1:0]               i1_alloc_phys,
  output logic                                alloc_stall,
  input  logic                                free0_valid,
  input  logic [PHYS_WIDTH-1:0]               free0_phys,
  input  logic                                free1_valid,
  input  logic [PHYS_WIDTH-1:0]               free1_phys,
  input  logic                                checkpoint,
  input  logic                                restore,
  input  logic [$clog2(CHECKPOINT_DEPTH)-1:0] checkpoint_restore_pos,
  output logic [$clog2(NUM_PHYS_REGS):0]      free_count,
  output logic                                overflow_err
);

  localparam int PTR_W     = $clog2(NUM_PHYS_REGS) + 1;
  localparam int IDX_W     = PTR_W - 1;
  localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

  logic [PHYS_WIDTH-1:0] entries [NUM_PHYS_REGS];
  logic [PTR_W-1:0]      head, tail;

  logic [PTR_W-1:0] need;
  logic [PTR_W-1:0] head_i1, head_alloc, head_next, snap_rd;
  logic [PTR_W-1:0] tail_i1;
  logic             grant, restore_req;
  logic             fw0, fw1, w0, w1, drop_full;

`ifdef TBOOM_FREE_LIST_CHECKPOINT_EN
  logic checkpoint_req;

  assign restore_req    = restore;
  // A simultaneous restore discards the snapshot write.
  assign checkpoint_req = checkpoint & ~restore;

  tboom_fl_checkpoint_buf #(
    .DEPTH (CHECKPOINT_DEPTH),
    .PTR_W (PTR_W)
  ) u_checkpoint_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (checkpoint_req),
    .wr_pos (checkpoint_restore_pos),
    .wr_ptr (head_alloc),
    .rd_pos (checkpoint_restore_pos),
    .rd_ptr (snap_rd)
  );
`else
  logic unused_ckpt;

  assign restore_req = 1'b0;
  assign snap_rd     = '0;
  assign unused_ckpt = ^{checkpoint, restore, checkpoint_restore_pos};
`endif

  assign free_count = tail - head;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    need           = PTR_W'(i0_freelist_request) + PTR_W'(i1_freelist_request);
    alloc_stall    = restore_req | (need > free_count);
    grant          = ~alloc_stall;
    head_i1        = head + PTR_W'(i0_freelist_request);

    i0_alloc_valid = i0_freelist_request & grant;
    i1_alloc_valid = i1_freelist_request & grant;
    i0_alloc_phys  = '0;
    i1_alloc_phys  = '0;
    if (i0_alloc_valid) i0_alloc_phys = entries[head[IDX_W-1:0]];
    if (i1_alloc_valid) i1_alloc_phys = entries[head_i1[IDX_W-1:0]];

    head_alloc = grant ? head + need : head;
    head_next  = restore_req ? snap_rd : head_alloc;
  end

  // Frees are checked against the occupancy at the start of the cycle; free0
  // is placed first so free1 sees one fewer slot when free0 is accepted.
  always_comb begin
    fw0       = free0_valid & (free0_phys != '0);
    fw1       = free1_valid & (free1_phys != '0);
    w0        = fw0 & (free_count < PTR_W'(NUM_PHYS_REGS));
    w1        = fw1 & ((free_count + PTR_W'(w0)) < PTR_W'(NUM_PHYS_REGS));
    drop_full = (fw0 & ~w0) | (fw1 & ~w1);
    tail_i1   = tail + PTR_W'(w0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= PTR_W'(INIT_FREE);
      overflow_err <= 1'b0;
      // NOTE: the entry array is reset on purpose; the initial free registers
      // must be present from the first allocation cycle.
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        if (i < INIT_FREE) entries[i] <= PHYS_WIDTH'(fl_reset_fill(NUM_ARCH_REGS, i));
        else               entries[i] <= '0;
      end
    end else begin
      head <= head_next;
      tail <= tail_i1 + PTR_W'(w1);
      if (w0)        entries[tail[IDX_W-1:0]]    <= free0_phys;
      if (w1)        entries[tail_i1[IDX_W-1:0]] <= free1_phys;
      if (drop_full) overflow_err                <= 1'b1;
    end
  end

endmodule
